// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction memory port, execute redirect and decode-side handshake.
// master = fetch unit, slave = surrounding core / testbench.
interface instr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;
  logic        halted;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr, out_pc_plus4, fault, fault_pc, halted,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr, out_pc_plus4, fault, fault_pc, halted,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, 2-entry {pc, instr} buffer, redirect and address-fault handling.
// Optional self-loop halt detection is enabled by defining IFU_HALT_DETECT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_unit_if.master bus
);

  localparam logic StRun   = 1'b0;
  localparam logic StFault = 1'b1;
  localparam logic [31:0] ImemWords = 32'(IMEM_WORDS);

  logic [31:0] r_fetch_pc;
  logic [31:0] r_pc    [2];
  logic [31:0] r_instr [2];
  logic        r_head;
  logic [1:0]  r_count;
  logic        r_mode;
  logic [31:0] r_fault_pc;

  logic w_addr_ok;
  logic w_redir_ok;
  logic w_pop;
  logic w_push;
  logic w_tail;
  logic w_halt;

  always_comb begin
    w_addr_ok  = (r_fetch_pc[1:0] == 2'b00) && (32'(r_fetch_pc[31:2]) < ImemWords);
    w_redir_ok = (bus.redirect_pc[1:0] == 2'b00) && (32'(bus.redirect_pc[31:2]) < ImemWords);
    w_pop      = (r_count != 2'd0) && bus.out_ready;
    w_push     = (r_mode == StRun) && !bus.redirect_valid && !w_halt && w_addr_ok &&
                 ((r_count != 2'd2) || w_pop);
    // head + count modulo 2; at count 2 this is the slot being popped
    w_tail     = r_head ^ r_count[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_pc[0]    <= 32'h0;
      r_pc[1]    <= 32'h0;
      r_instr[0] <= 32'h0;
      r_instr[1] <= 32'h0;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
      r_mode     <= StRun;
      r_fault_pc <= 32'h0;
    end else if (bus.redirect_valid) begin
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_fetch_pc <= bus.redirect_pc;
      // In RUN a bad target is caught next cycle by the normal address check
      if (r_mode == StFault) begin
        if (w_redir_ok) begin
          r_mode <= StRun;
        end else begin
          r_fault_pc <= bus.redirect_pc;
        end
      end
    end else begin
      if (w_push) begin
        r_pc[w_tail]    <= r_fetch_pc;
        r_instr[w_tail] <= bus.imem_rdata;
        r_fetch_pc      <= r_fetch_pc + 32'd4;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if ((r_mode == StRun) && !w_addr_ok) begin
        r_mode     <= StFault;
        r_fault_pc <= r_fetch_pc;
      end
    end
  end

`ifdef IFU_HALT_DETECT_EN
  localparam logic [31:0] JalSelf = 32'h0000_006F;
  logic r_halt_flag;
  logic r_halted;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_halt_flag <= 1'b0;
      r_halted    <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_halt_flag <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      if (w_push && (bus.imem_rdata == JalSelf)) begin
        r_halt_flag <= 1'b1;
      end
      if (w_pop && (r_instr[r_head] == JalSelf)) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign w_halt     = r_halt_flag;
  assign bus.halted = r_halted;
`else
  assign w_halt     = 1'b0;
  assign bus.halted = 1'b0;
`endif

  assign bus.imem_addr    = r_fetch_pc;
  assign bus.out_valid    = (r_count != 2'd0);
  assign bus.out_pc       = r_pc[r_head];
  assign bus.out_instr    = r_instr[r_head];
  assign bus.out_pc_plus4 = r_pc[r_head] + 32'd4;
  assign bus.fault        = (r_mode == StFault);
  assign bus.fault_pc     = r_fault_pc;

endmodule
